xif_offload_ctrl: RTL and testbench
===================================

XIF_OFFLOAD_CTRL -- requirements
Module: xif_offload_ctrl

Interface
REQ-001 Parameter MAX_OUTSTANDING, default 4, SHALL set the maximum accepted-but-unanswered offloads; legal range 1..16.
REQ-002 clk_i  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_i  in  1  reset; synchronous and active-high.
REQ-004 core_req_valid_i  in  1  core offers an instruction for offload.
REQ-005 core_req_ready_o  out  1  block accepts the core offer this cycle.
REQ-006 core_instr_i / core_rs_i / core_hart_id_i  in  32 / 3x32 / 32  instruction word, integer operands, hart id.
REQ-007 c_q_valid_o, c_q_ready_i  out/in  1 each  C-request handshake toward the accelerator.
REQ-008 c_q_addr_o / c_q_rs_o / c_q_instr_data_o / c_q_hart_id_o  out  5 / 3x32 / 32 / 32  request payload; addr SHALL be core_instr_i[11:7].
REQ-009 c_p_valid_i, c_p_ready_o  in/out  1 each  C-response handshake.
REQ-010 c_p_data_i / c_p_error_i / c_p_dualwb_i / c_p_hart_id_i / c_p_rd_i  in  32 / 1 / 1 / 32 / 5  response payload.
REQ-011 wb_valid_o, wb_ready_i  out/in  1 each  writeback handshake toward the integer register file.
REQ-012 wb_addr_o / wb_data_o / wb_dualwb_o / wb_error_o  out  5 / 32 / 1 / 1  writeback payload.
REQ-013 busy_o  out  1  high while the outstanding count is nonzero or any output register is valid.

Function
REQ-014 Request stage SHALL be one output register; core_req_ready_o = (!c_q_valid_o || c_q_ready_i) && (outstanding + c_q_valid_o < MAX_OUTSTANDING).
REQ-015 On core handshake the payload SHALL be registered and c_q_valid_o asserted the next cycle, giving 1-cycle latency.
REQ-016 While c_q_valid_o && !c_q_ready_i, all c_q_* outputs SHALL stay stable.
REQ-017 A request handshake SHALL push c_q_addr_o into an in-order rd tracker FIFO of depth MAX_OUTSTANDING and increment the outstanding counter.
REQ-018 A response handshake SHALL pop the tracker and decrement the counter; simultaneous push and pop SHALL leave the count unchanged.
REQ-019 The counter SHALL be $clog2(MAX_OUTSTANDING+1) bits and SHALL never exceed MAX_OUTSTANDING or underflow.
REQ-020 c_p_ready_o = (outstanding != 0) && (!wb_valid_o || wb_ready_i).
REQ-021 A c_p_valid_i arriving with outstanding == 0 SHALL NOT be accepted and SHALL NOT change state.
REQ-022 On response handshake, wb_* SHALL be registered and wb_valid_o asserted the next cycle: wb_addr_o = tracker head, wb_data_o = c_p_data_i, wb_dualwb_o = c_p_dualwb_i, wb_error_o = c_p_error_i.
REQ-023 While wb_valid_o && !wb_ready_i, wb_* SHALL stay stable.
REQ-024 Back-to-back operation SHALL sustain one request and one response per cycle when the peers are always ready.
REQ-025 Responses SHALL be assumed in order; the tracker SHALL pair them with requests strictly in issue order.

Reset
REQ-026 While rst_i is high at a clock edge: c_q_valid_o = 0, wb_valid_o = 0, core_req_ready_o = 0, c_p_ready_o = 0, counter = 0, tracker empty, busy_o = 0, and all payload outputs = 0.
REQ-027 A reset asserted mid-transaction SHALL discard all in-flight state; no writeback SHALL be emitted for pre-reset requests.
REQ-028 core_req_ready_o SHALL first assert in the cycle after rst_i deasserts.

Configuration
REQ-029 Macro XIF_RD_CHECK_EN: when defined, on response handshake wb_error_o SHALL be c_p_error_i || (c_p_rd_i != tracker head); when undefined, c_p_rd_i SHALL be ignored and wb_error_o = c_p_error_i.

Verification
REQ-030 Single offload: instr 32'h0000_0553 (rd=10), ready peers -> c_q_valid_o at cycle+1 with addr 10; response data 32'hDEAD_BEEF -> wb_valid_o next cycle with addr 10, data DEADBEEF.
REQ-031 Limit: MAX_OUTSTANDING=4, c_p_valid_i held low, 5 offers -> exactly 4 request handshakes; core_req_ready_o stays low until the first response is accepted.
REQ-032 Stall: c_q_ready_i low 3 cycles, then wb_ready_i low 2 cycles -> c_q_* and wb_* remain stable and no data is lost or duplicated.
REQ-033 Ordering: rd 1,2,3 issued back-to-back, responses 0x11,0x22,0x33 -> writebacks (1,0x11),(2,0x22),(3,0x33) in order; a response accepted in the same cycle as a request leaves the count unchanged.
REQ-034 Reset mid-flight with 2 outstanding -> all valids 0 the next cycle, busy_o=0, and no writeback afterward.
REQ-035 With XIF_RD_CHECK_EN defined, response c_p_rd_i=7 for tracked rd 5 -> wb_error_o=1; undefined -> wb_error_o=0.

Source files
------------

// File: rtl/xif_offload_ctrl.sv
// XIF offload controller: registered C-request / writeback stages with an in-order rd tracker.
// Optional macro XIF_RD_CHECK_EN flags a writeback error when the returned rd differs from the tracked rd.
module xif_offload_ctrl #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_valid_i,
    output logic        core_req_ready_o,
    input  logic [31:0] core_instr_i,
    input  logic [95:0] core_rs_i,
    input  logic [31:0] core_hart_id_i,
    output logic        c_q_valid_o,
    input  logic        c_q_ready_i,
    output logic [4:0]  c_q_addr_o,
    output logic [95:0] c_q_rs_o,
    output logic [31:0] c_q_instr_data_o,
    output logic [31:0] c_q_hart_id_o,
    input  logic        c_p_valid_i,
    output logic        c_p_ready_o,
    input  logic [31:0] c_p_data_i,
    input  logic        c_p_error_i,
    input  logic        c_p_dualwb_i,
    input  logic [31:0] c_p_hart_id_i,
    input  logic [4:0]  c_p_rd_i,
    output logic        wb_valid_o,
    input  logic        wb_ready_i,
    output logic [4:0]  wb_addr_o,
    output logic [31:0] wb_data_o,
    output logic        wb_dualwb_o,
    output logic        wb_error_o,
    output logic        busy_o
);

    localparam int CW    = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int LASTI = MAX_OUTSTANDING - 1;
    localparam logic [CW:0]   MAXV  = MAX_OUTSTANDING[CW:0];
    localparam logic [PW-1:0] LASTP = LASTI[PW-1:0];

    logic          r_active;
    logic          r_q_valid;
    logic [4:0]    r_q_addr;
    logic [95:0]   r_q_rs;
    logic [31:0]   r_q_instr;
    logic [31:0]   r_q_hart;
    logic          r_wb_valid;
    logic [4:0]    r_wb_addr;
    logic [31:0]   r_wb_data;
    logic          r_wb_dualwb;
    logic          r_wb_error;
    logic [CW-1:0] r_cnt;
    logic [4:0]    r_trk [MAX_OUTSTANDING];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;

    logic          w_run;
    logic          w_core_hs;
    logic          w_req_hs;
    logic          w_rsp_hs;
    logic [4:0]    w_head;
    logic          w_err;
    logic [CW:0]   w_sum;
    logic          w_unused;

    // r_active holds ready low until the first cycle after reset is released
    assign w_run     = r_active && !rst_i;
    assign w_sum     = {1'b0, r_cnt} + {{CW{1'b0}}, r_q_valid};
    assign w_head    = r_trk[r_rptr];
    assign w_core_hs = core_req_valid_i && core_req_ready_o;
    assign w_req_hs  = r_q_valid && c_q_ready_i;
    assign w_rsp_hs  = c_p_valid_i && c_p_ready_o;

    assign core_req_ready_o = w_run && (!r_q_valid || c_q_ready_i)
                              && (w_sum < MAXV);
    assign c_p_ready_o      = w_run && (r_cnt != '0)
                              && (!r_wb_valid || wb_ready_i);

`ifdef XIF_RD_CHECK_EN
    assign w_err    = c_p_error_i || (c_p_rd_i != w_head);
    assign w_unused = ^c_p_hart_id_i;
`else
    assign w_err    = c_p_error_i;
    assign w_unused = ^{c_p_hart_id_i, c_p_rd_i};
`endif

    assign c_q_valid_o      = r_q_valid;
    assign c_q_addr_o       = r_q_addr;
    assign c_q_rs_o         = r_q_rs;
    assign c_q_instr_data_o = r_q_instr;
    assign c_q_hart_id_o    = r_q_hart;
    assign wb_valid_o       = r_wb_valid;
    assign wb_addr_o        = r_wb_addr;
    assign wb_data_o        = r_wb_data;
    assign wb_dualwb_o      = r_wb_dualwb;
    assign wb_error_o       = r_wb_error;
    assign busy_o           = (r_cnt != '0) || r_q_valid || r_wb_valid;

    always_ff @(posedge clk_i) begin
        if (w_req_hs) begin
            r_trk[r_wptr] <= r_q_addr;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_active    <= 1'b0;
            r_q_valid   <= 1'b0;
            r_q_addr    <= '0;
            r_q_rs      <= '0;
            r_q_instr   <= '0;
            r_q_hart    <= '0;
            r_wb_valid  <= 1'b0;
            r_wb_addr   <= '0;
            r_wb_data   <= '0;
            r_wb_dualwb <= 1'b0;
            r_wb_error  <= 1'b0;
            r_cnt       <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
        end else begin
            r_active <= 1'b1;
            if (w_core_hs) begin
                r_q_valid <= 1'b1;
                r_q_addr  <= core_instr_i[11:7];
                r_q_rs    <= core_rs_i;
                r_q_instr <= core_instr_i;
                r_q_hart  <= core_hart_id_i;
            end else if (w_req_hs) begin
                r_q_valid <= 1'b0;
            end
            if (w_rsp_hs) begin
                r_wb_valid  <= 1'b1;
                r_wb_addr   <= w_head;
                r_wb_data   <= c_p_data_i;
                r_wb_dualwb <= c_p_dualwb_i;
                r_wb_error  <= w_err;
            end else if (wb_ready_i) begin
                r_wb_valid <= 1'b0;
            end
            if (w_req_hs) begin
                r_wptr <= (r_wptr == LASTP) ? '0 : r_wptr + PW'(1'b1);
            end
            if (w_rsp_hs) begin
                r_rptr <= (r_rptr == LASTP) ? '0 : r_rptr + PW'(1'b1);
            end
            unique case ({w_req_hs, w_rsp_hs})
                2'b10:   r_cnt <= r_cnt + CW'(1'b1);
                2'b01:   r_cnt <= r_cnt - CW'(1'b1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_xif_offload_ctrl.sv
// Testbench for xif_offload_ctrl: cycle tables, directed corner sequences,
// and randomized traffic against a queue-based transaction model.
module tb_xif_offload_ctrl;

    localparam int MAXO = 4;
`ifdef XIF_RD_CHECK_EN
    localparam bit RDCHK = 1'b1;
`else
    localparam bit RDCHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cv;
    logic        cr;
    logic [31:0] instr;
    logic [95:0] rs;
    logic [31:0] hart;
    logic        qv;
    logic        cq_ready;
    logic [4:0]  qa;
    logic [95:0] qrs;
    logic [31:0] qinstr;
    logic [31:0] qhart;
    logic        pv;
    logic        pr;
    logic [31:0] pdata;
    logic        perr;
    logic        pdual;
    logic [31:0] phart;
    logic [4:0]  prd;
    logic        wbv;
    logic        wb_ready;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        wdual;
    logic        werr;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    xif_offload_ctrl #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .core_req_valid_i (cv),
        .core_req_ready_o (cr),
        .core_instr_i     (instr),
        .core_rs_i        (rs),
        .core_hart_id_i   (hart),
        .c_q_valid_o      (qv),
        .c_q_ready_i      (cq_ready),
        .c_q_addr_o       (qa),
        .c_q_rs_o         (qrs),
        .c_q_instr_data_o (qinstr),
        .c_q_hart_id_o    (qhart),
        .c_p_valid_i      (pv),
        .c_p_ready_o      (pr),
        .c_p_data_i       (pdata),
        .c_p_error_i      (perr),
        .c_p_dualwb_i     (pdual),
        .c_p_hart_id_i    (phart),
        .c_p_rd_i         (prd),
        .wb_valid_o       (wbv),
        .wb_ready_i       (wb_ready),
        .wb_addr_o        (wa),
        .wb_data_o        (wd),
        .wb_dualwb_o      (wdual),
        .wb_error_o       (werr),
        .busy_o           (busy)
    );

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            if (errors < 30)
                $display("FAIL %s got %0h want %0h", n, a, e);
        end
    endtask

    task automatic idle_inputs();
        cv = 1'b0; instr = '0; rs = '0; hart = '0;
        cq_ready = 1'b1; pv = 1'b0; pdata = '0; perr = 1'b0;
        pdual = 1'b0; phart = '0; prd = '0; wb_ready = 1'b1;
    endtask

    function automatic logic [31:0] mk(input logic [4:0] rd);
        return 32'h0000_000B | {20'd0, rd, 7'd0};
    endfunction

    // cycle table: inputs, then outputs expected before the next rising edge
    typedef struct {
        logic        cv;
        logic [31:0] instr;
        logic        pv;
        logic [31:0] pdata;
        logic        e_cr;
        logic        e_qv;
        logic [4:0]  e_qa;
        logic        e_pr;
        logic        e_wv;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic        e_busy;
    } vec_t;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] instr;
        logic [95:0] rs;
        logic [31:0] hart;
    } req_t;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        dual;
        logic        err;
    } wbx_t;

    task automatic one_txn(input string n, input logic [4:0] rd,
                           input logic [4:0] prd_v, input logic perr_v,
                           input logic pdual_v, input logic [31:0] d);
        logic e_err;
        e_err = perr_v || (RDCHK && (prd_v != rd));
        @(negedge clk); idle_inputs(); cv = 1'b1; instr = mk(rd); #1;
        @(negedge clk); cv = 1'b0; instr = '0; #1;
        chk({n, "_qv"}, 32'(qv), 32'd1);
        @(negedge clk); pv = 1'b1; prd = prd_v; perr = perr_v;
        pdual = pdual_v; pdata = d; #1;
        chk({n, "_pr"}, 32'(pr), 32'd1);
        @(negedge clk); idle_inputs(); #1;
        chk({n, "_wv"}, 32'(wbv), 32'd1);
        chk({n, "_wa"}, 32'(wa), 32'(rd));
        chk({n, "_wd"}, wd, d);
        chk({n, "_dual"}, 32'(wdual), 32'(pdual_v));
        chk({n, "_err"}, 32'(werr), 32'(e_err));
        @(negedge clk); idle_inputs(); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl [12];
        req_t pendq [$];
        wbx_t wbq [$];
        logic [4:0] trk [$];
        int nc;
        int nq;
        int np;
        int nbad;

        tbl[0]  = '{1'b1, 32'h0000_0553, 1'b0, 32'h0,
                    1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0};
        tbl[1]  = '{1'b0, 32'h0, 1'b0, 32'h0,
                    1'b1, 1'b1, 5'd10, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1};
        tbl[2]  = '{1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF,
                    1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1};
        tbl[3]  = '{1'b0, 32'h0, 1'b0, 32'h0,
                    1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 5'd10, 32'hDEAD_BEEF, 1'b1};
        tbl[4]  = '{1'b0, 32'h0, 1'b0, 32'h0,
                    1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0};
        tbl[5]  = '{1'b1, mk(5'd1), 1'b0, 32'h0,
                    1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0};
        tbl[6]  = '{1'b1, mk(5'd2), 1'b0, 32'h0,
                    1'b1, 1'b1, 5'd1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1};
        tbl[7]  = '{1'b1, mk(5'd3), 1'b1, 32'h11,
                    1'b1, 1'b1, 5'd2, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1};
        tbl[8]  = '{1'b0, 32'h0, 1'b1, 32'h22,
                    1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 5'd1, 32'h11, 1'b1};
        tbl[9]  = '{1'b0, 32'h0, 1'b1, 32'h33,
                    1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 5'd2, 32'h22, 1'b1};
        tbl[10] = '{1'b0, 32'h0, 1'b0, 32'h0,
                    1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3, 32'h33, 1'b1};
        tbl[11] = '{1'b0, 32'h0, 1'b0, 32'h0,
                    1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0};

        // reset state, with offers present to prove they are refused
        idle_inputs();
        rst = 1'b1; cv = 1'b1; instr = mk(5'd9); pv = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_cr", 32'(cr), 32'd0);
        chk("rst_qv", 32'(qv), 32'd0);
        chk("rst_pr", 32'(pr), 32'd0);
        chk("rst_wv", 32'(wbv), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_qa", 32'(qa), 32'd0);
        chk("rst_wd", wd, 32'd0);
        @(negedge clk); idle_inputs(); rst = 1'b0; cv = 1'b1; #1;
        chk("rdy_first_low", 32'(cr), 32'd0);
        @(negedge clk); cv = 1'b0; #1;
        chk("rdy_after", 32'(cr), 32'd1);

        // single offload and in-order pairing
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            idle_inputs();
            cv = tbl[i].cv; instr = tbl[i].instr; rs = {3{tbl[i].instr}};
            pv = tbl[i].pv; pdata = tbl[i].pdata;
            #1;
            chk($sformatf("v%0d_cr", i), 32'(cr), 32'(tbl[i].e_cr));
            chk($sformatf("v%0d_qv", i), 32'(qv), 32'(tbl[i].e_qv));
            chk($sformatf("v%0d_pr", i), 32'(pr), 32'(tbl[i].e_pr));
            chk($sformatf("v%0d_wv", i), 32'(wbv), 32'(tbl[i].e_wv));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
            if (tbl[i].e_qv)
                chk($sformatf("v%0d_qa", i), 32'(qa), 32'(tbl[i].e_qa));
            if (tbl[i].e_wv) begin
                chk($sformatf("v%0d_wa", i), 32'(wa), 32'(tbl[i].e_wa));
                chk($sformatf("v%0d_wd", i), wd, tbl[i].e_wd);
            end
        end

        // outstanding limit with no responses
        nc = 0; nq = 0;
        repeat (8) begin
            @(negedge clk); idle_inputs(); cv = 1'b1; instr = mk(5'd9); #1;
            if (cv && cr) nc++;
            if (qv && cq_ready) nq++;
        end
        chk("lim_core_hs", 32'(nc), 32'd4);
        chk("lim_req_hs", 32'(nq), 32'd4);
        chk("lim_busy", 32'(busy), 32'd1);
        @(negedge clk); pv = 1'b1; pdata = 32'h100; #1;
        chk("lim_hold", 32'(cr), 32'd0);
        chk("lim_pr", 32'(pr), 32'd1);
        @(negedge clk); idle_inputs(); #1;
        chk("lim_release", 32'(cr), 32'd1);
        chk("lim_wa", 32'(wa), 32'd9);
        np = 0;
        for (int k = 0; k < 20 && np < 3; k++) begin
            @(negedge clk); idle_inputs(); pv = 1'b1; #1;
            if (pr) np++;
        end
        chk("lim_drain", 32'(np), 32'd3);
        repeat (2) begin
            @(negedge clk); idle_inputs(); #1;
        end
        chk("lim_idle", 32'(busy), 32'd0);

        // request and writeback stalls
        @(negedge clk); idle_inputs(); cv = 1'b1; instr = mk(5'd5);
        rs = 96'h0123_4567_89AB_CDEF_0F0F_0F0F; hart = 32'h7; cq_ready = 1'b0; #1;
        chk("st_accept", 32'(cr), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); idle_inputs(); cq_ready = 1'b0; #1;
            chk($sformatf("st_q%0d_v", k), 32'(qv), 32'd1);
            chk($sformatf("st_q%0d_a", k), 32'(qa), 32'd5);
            chk($sformatf("st_q%0d_rs", k), qrs[95:64], 32'h0123_4567);
            chk($sformatf("st_q%0d_rs0", k), qrs[31:0], 32'h0F0F_0F0F);
            chk($sformatf("st_q%0d_i", k), qinstr, mk(5'd5));
            chk($sformatf("st_q%0d_h", k), qhart, 32'h7);
            chk($sformatf("st_q%0d_cr", k), 32'(cr), 32'd0);
        end
        @(negedge clk); idle_inputs(); #1;
        chk("st_q_go", 32'(qv), 32'd1);
        @(negedge clk); idle_inputs(); pv = 1'b1; pdata = 32'h55;
        wb_ready = 1'b0; #1;
        chk("st_q_done", 32'(qv), 32'd0);
        chk("st_pr", 32'(pr), 32'd1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); idle_inputs(); pv = 1'b1; pdata = 32'h66;
            wb_ready = 1'b0; #1;
            chk($sformatf("st_w%0d_v", k), 32'(wbv), 32'd1);
            chk($sformatf("st_w%0d_a", k), 32'(wa), 32'd5);
            chk($sformatf("st_w%0d_d", k), wd, 32'h55);
            chk($sformatf("st_w%0d_pr0", k), 32'(pr), 32'd0);
        end
        @(negedge clk); idle_inputs(); #1;
        chk("st_w_go", 32'(wbv), 32'd1);
        @(negedge clk); idle_inputs(); #1;
        chk("st_w_nodup", 32'(wbv), 32'd0);
        chk("st_idle", 32'(busy), 32'd0);

        // reset with two requests in flight
        @(negedge clk); idle_inputs(); cv = 1'b1; instr = mk(5'd3); #1;
        @(negedge clk); idle_inputs(); cv = 1'b1; instr = mk(5'd4); #1;
        @(negedge clk); idle_inputs(); #1;
        @(negedge clk); idle_inputs(); rst = 1'b1; #1;
        chk("mr_busy_pre", 32'(busy), 32'd1);
        @(negedge clk); idle_inputs(); rst = 1'b0; pv = 1'b1; #1;
        chk("mr_qv", 32'(qv), 32'd0);
        chk("mr_wv", 32'(wbv), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_pr", 32'(pr), 32'd0);
        nbad = 0;
        repeat (5) begin
            @(negedge clk); idle_inputs(); pv = 1'b1; #1;
            if (wbv || pr) nbad++;
        end
        chk("mr_no_wb", 32'(nbad), 32'd0);

        // returned rd versus tracked rd, error and dual-writeback passthrough
        one_txn("rd_mis", 5'd5, 5'd7, 1'b0, 1'b0, 32'hA);
        one_txn("rd_ok", 5'd5, 5'd5, 1'b0, 1'b1, 32'hB);
        one_txn("rd_err", 5'd5, 5'd5, 1'b1, 1'b0, 32'hC);

        // randomized traffic against the transaction model
        @(negedge clk); idle_inputs(); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 3000; c++) begin
            bit m_qv;
            bit m_wv;
            bit m_cr;
            bit m_pr;
            int m_out;
            req_t nr;
            wbx_t nw;
            @(negedge clk);
            cv = ($urandom_range(1) == 1);
            instr = $urandom; rs = {$urandom, $urandom, $urandom};
            hart = $urandom;
            cq_ready = ($urandom_range(3) != 0);
            pv = ($urandom_range(4) < 3);
            pdata = $urandom; perr = ($urandom_range(7) == 0);
            pdual = ($urandom_range(1) == 1); phart = $urandom;
            prd = 5'($urandom_range(31));
            wb_ready = ($urandom_range(3) != 0);
            #1;
            m_qv  = (pendq.size() != 0);
            m_wv  = (wbq.size() != 0);
            m_out = trk.size();
            m_cr  = (!m_qv || cq_ready) && (m_out + int'(m_qv) < MAXO);
            m_pr  = (m_out != 0) && (!m_wv || wb_ready);
            chk("r_cr", 32'(cr), 32'(m_cr));
            chk("r_qv", 32'(qv), 32'(m_qv));
            chk("r_pr", 32'(pr), 32'(m_pr));
            chk("r_wv", 32'(wbv), 32'(m_wv));
            chk("r_busy", 32'(busy), 32'(m_out != 0 || m_qv || m_wv));
            if (m_qv) begin
                chk("r_qa", 32'(qa), 32'(pendq[0].addr));
                chk("r_qi", qinstr, pendq[0].instr);
                chk("r_qrs", qrs[63:32], pendq[0].rs[63:32]);
                chk("r_qh", qhart, pendq[0].hart);
            end
            if (m_wv) begin
                chk("r_wa", 32'(wa), 32'(wbq[0].addr));
                chk("r_wd", wd, wbq[0].data);
                chk("r_wdual", 32'(wdual), 32'(wbq[0].dual));
                chk("r_werr", 32'(werr), 32'(wbq[0].err));
            end
            if (m_qv && cq_ready) begin
                trk.push_back(pendq[0].addr);
                void'(pendq.pop_front());
            end
            if (m_wv && wb_ready) void'(wbq.pop_front());
            if (m_pr && pv) begin
                nw.addr = trk.pop_front();
                nw.data = pdata;
                nw.dual = pdual;
                nw.err  = perr || (RDCHK && (prd != nw.addr));
                wbq.push_back(nw);
            end
            if (cv && m_cr) begin
                nr.addr = instr[11:7]; nr.instr = instr;
                nr.rs = rs; nr.hart = hart;
                pendq.push_back(nr);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
